// File: rtl/ecpa_pkg.sv
// Shared types and constants for the nibble-serial adder: FSM state encoding,
// slice width, and the nibble-count helper used to size the operation.
package ecpa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_adder_4b.sv
// Combinational 4-bit adder slice with carry in/out; zero latency, no state,
// no flow control.
module nibble_adder_4b
  import ecpa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    s     = total[NIBBLE_W-1:0];
    cout  = total[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial adder, one nibble per cycle LSB first; result valid WIDTH/4+1 cycles after accept.
// Backpressure: result held in DONE until out_ready; new operands refused until then.
module nibble_serial_adder
  import ecpa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB     = nib_count(WIDTH);
  localparam int CNT_W   = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int SUB_W   = $clog2(NIBBLE_W);
  localparam int IDX_W   = CNT_W + SUB_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [IDX_W-1:0]    nib_lsb;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_co;

  // The counter selects which nibble of the captured operands feeds the slice.
  always_comb begin
    nib_lsb = {cnt_q, {SUB_W{1'b0}}};
    nib_a   = a_q[nib_lsb +: NIBBLE_W];
    nib_b   = b_q[nib_lsb +: NIBBLE_W];
  end

  nibble_adder_4b u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[nib_lsb +: NIBBLE_W] = nib_s;
        carry_d                    = nib_co;
        if (cnt_q == CNT_LAST) begin
          cout_d  = nib_co;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    sum       = sum_q;
    cout      = cout_q;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter: WIDTH, default 32, operand/sum width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand pair a/b/cin is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in to nibble 0.
REQ-009 out_valid  output  1  sum/cout hold a completed result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
REQ-012 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 The block SHALL compute the sum one 4-bit nibble per cycle, least significant nibble first, through a single 4-bit adder slice, with NIB = WIDTH/4 nibble cycles per operation.
REQ-014 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-015 IDLE: in_ready=1, out_valid=0; in_valid=1 SHALL capture a, b, cin into operand registers, clear nibble counter to 0, and move to RUN.
REQ-016 RUN: in_ready=0, out_valid=0; each cycle the slice SHALL add nibble[cnt] of a, b with the carry register (cin for cnt=0), write the 4-bit result into sum[4*cnt+3:4*cnt], store the slice carry-out in the carry register, and increment cnt.
REQ-017 On the RUN cycle with cnt=NIB-1, the block SHALL latch the slice carry-out into cout and move to DONE.
REQ-018 DONE: out_valid=1, in_ready=0; sum and cout SHALL stay stable until out_ready=1, after which the next state is IDLE.
REQ-019 Latency: operands accepted at edge T -> out_valid asserted after edge T+NIB (NIB+1 cycles from acceptance cycle to first out_valid cycle); throughput one operation per NIB+2 cycles.
REQ-020 in_valid during RUN or DONE SHALL be ignored; a/b/cin changes after capture SHALL not affect the result.
REQ-021 out_ready while not in DONE SHALL be ignored.
REQ-022 Overflow: cout=1 exactly when a + b + cin >= 2^WIDTH; sum wraps modulo 2^WIDTH.
REQ-023 Counter cnt SHALL be ceil(log2(NIB)) bits and SHALL never exceed NIB-1.

Reset
REQ-024 rst=1 SHALL force state IDLE, cnt=0, carry register=0, sum=0, cout=0, out_valid=0, in_ready=1 on the next edge.
REQ-025 rst asserted mid-RUN or in DONE SHALL abort the operation with no result presented; rst has priority over in_valid and out_ready in the same cycle.
REQ-026 First cycle after rst deasserts, the block SHALL accept in_valid=1.

Structure
REQ-027 Shared package ecpa_pkg SHALL hold the FSM state typedef and the NIBBLE_W=4 constant.
REQ-028 One sub-module, nibble_adder_4b, SHALL be a purely combinational 4-bit adder (a[3:0], b[3:0], cin -> s[3:0], cout); all registers live in nibble_serial_adder.

Verification
REQ-029 WIDTH=32: a=0x0000_0001, b=0x0000_0002, cin=0 -> after 8 nibble cycles sum=0x0000_0003, cout=0.
REQ-030 Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1; carry propagates across all 8 nibbles.
REQ-031 Backpressure: a=0x1234_5678, b=0x1111_1111, cin=0, out_ready=0 for 5 cycles in DONE -> sum=0x2345_6789 held stable, in_ready=0 throughout, new in_valid ignored.
REQ-032 Reset mid-RUN: rst at cnt=3 -> next cycle out_valid=0, in_ready=1, sum=0, cout=0; following op a=0x8000_0000, b=0x8000_0000 -> sum=0x0000_0000, cout=1.
REQ-033 Back-to-back: in_valid held high, out_ready held high, 100 random pairs -> each result matches a+b+cin with spacing exactly NIB+2 cycles.
REQ-034 WIDTH=8: a=0xF0, b=0x0F, cin=1 -> sum=0x00, cout=1 after 2 nibble cycles.
